// File: rtl/kw_token_scanner_if.sv
// Byte-in / token-out handshake bundle for the keyword token scanner.
// master = byte source and token sink, slave = scanner.
interface kw_token_scanner_if #(
    parameter int HASH_W = 12,
    parameter int LINE_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              in_last;
    logic              tok_valid;
    logic              tok_ready;
    logic [1:0]        tok_kind;
    logic [7:0]        tok_len;
    logic [HASH_W-1:0] tok_hash;
    logic [LINE_W-1:0] tok_line;
    logic              tok_trunc;

    modport master (
        output in_valid, in_data, in_last, tok_ready,
        input  in_ready, tok_valid, tok_kind, tok_len, tok_hash, tok_line, tok_trunc
    );

    modport slave (
        input  in_valid, in_data, in_last, tok_ready,
        output in_ready, tok_valid, tok_kind, tok_len, tok_hash, tok_line, tok_trunc
    );
endinterface

// File: rtl/kw_token_scanner.sv
// Splits an ASCII byte stream into WORD / DIRECTIVE / PUNCT / EOF tokens
// carrying a rotate-xor hash, saturating length and source line number.
//
// state  | meaning
// IDLE   | between tokens, whitespace skipped
// WORD   | accumulating a word or directive
// PEND   | word emitted, terminating punct/'#' waits for the output slot
// EOF    | end of file seen, EOF token waits for the output slot
module kw_token_scanner #(
    parameter int MAX_LEN = 16,
    parameter int HASH_W  = 12,
    parameter int LINE_W  = 16
) (
    input logic              clk,
    input logic              rst_n,
    kw_token_scanner_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WORD, S_PEND, S_EOF} state_t;

    localparam logic [1:0] K_WORD  = 2'd0;
    localparam logic [1:0] K_DIR   = 2'd1;
    localparam logic [1:0] K_PUNCT = 2'd2;
    localparam logic [1:0] K_EOF   = 2'd3;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    function automatic logic is_word(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) || (b >= 8'h41 && b <= 8'h5A) ||
               (b >= 8'h30 && b <= 8'h39) || b == 8'h5F || b == 8'h24;
    endfunction

    function automatic logic is_ws(input logic [7:0] b);
        return b == 8'h20 || b == 8'h09 || b == 8'h0D || b == 8'h0A;
    endfunction

    function automatic logic [HASH_W-1:0] hash_step(input logic [HASH_W-1:0] h,
                                                    input logic [7:0] b);
        return {h[HASH_W-6:0], h[HASH_W-1:HASH_W-5]} ^ HASH_W'(b);
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          kind_q, kind_d;
    logic [7:0]          len_q, len_d;
    logic [HASH_W-1:0]   hash_q, hash_d;
    logic [LINE_W-1:0]   line0_q, line0_d;
    logic                trunc_q, trunc_d;
    logic [7:0]          pend_q, pend_d;
    logic                pend_last_q, pend_last_d;
    logic [LINE_W-1:0]   line_q, line_d;

    logic                tv_q;
    logic [1:0]          tk_q;
    logic [7:0]          tl_q;
    logic [HASH_W-1:0]   th_q;
    logic [LINE_W-1:0]   tln_q;
    logic                tt_q;

    logic                slot_free, in_ready, acc;
    logic                load, ld_trunc;
    logic [1:0]          ld_kind;
    logic [7:0]          ld_len;
    logic [HASH_W-1:0]   ld_hash;
    logic [LINE_W-1:0]   ld_line;
    logic                proc_go, proc_last;
    logic [7:0]          proc_b;
    logic [7:0]          app_len;
    logic [HASH_W-1:0]   app_hash;
    logic                app_trunc;

    always_comb begin
        slot_free   = !tv_q || bus.tok_ready;
        // Ready is withheld whenever the slot is busy, since any byte may end a token.
        in_ready    = rst_n && slot_free && (state_q == S_IDLE || state_q == S_WORD);
        acc         = bus.in_valid && in_ready;
        state_d     = state_q;
        kind_d      = kind_q;
        len_d       = len_q;
        hash_d      = hash_q;
        line0_d     = line0_q;
        trunc_d     = trunc_q;
        pend_d      = pend_q;
        pend_last_d = pend_last_q;
        line_d      = line_q;
        load        = 1'b0;
        ld_kind     = K_WORD;
        ld_len      = 8'd0;
        ld_hash     = '0;
        ld_line     = line_q;
        ld_trunc    = 1'b0;
        proc_go     = 1'b0;
        proc_b      = bus.in_data;
        proc_last   = bus.in_last;

        if (len_q < MAX_LEN_B) begin
            app_len   = len_q + 8'd1;
            app_hash  = hash_step(hash_q, bus.in_data);
            app_trunc = trunc_q;
        end else begin
            app_len   = len_q;
            app_hash  = hash_q;
            app_trunc = 1'b1;
        end

        case (state_q)
            S_IDLE: proc_go = acc;
            S_WORD: begin
                if (acc) begin
                    if (is_word(bus.in_data)) begin
                        if (bus.in_last) begin
                            load     = 1'b1;
                            ld_kind  = kind_q;
                            ld_len   = app_len;
                            ld_hash  = app_hash;
                            ld_line  = line0_q;
                            ld_trunc = app_trunc;
                            state_d  = S_EOF;
                        end else begin
                            len_d   = app_len;
                            hash_d  = app_hash;
                            trunc_d = app_trunc;
                        end
                    end else begin
                        load     = 1'b1;
                        ld_kind  = kind_q;
                        ld_len   = len_q;
                        ld_hash  = hash_q;
                        ld_line  = line0_q;
                        ld_trunc = trunc_q;
                        if (is_ws(bus.in_data)) begin
                            state_d = bus.in_last ? S_EOF : S_IDLE;
                        end else begin
                            pend_d      = bus.in_data;
                            pend_last_d = bus.in_last;
                            state_d     = S_PEND;
                        end
                    end
                end
            end
            S_PEND: begin
                proc_go   = slot_free;
                proc_b    = pend_q;
                proc_last = pend_last_q;
            end
            S_EOF: begin
                if (slot_free) begin
                    load    = 1'b1;
                    ld_kind = K_EOF;
                    line_d  = LINE_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Token start shared by IDLE and the replayed byte in PEND.
        if (proc_go) begin
            if (is_word(proc_b) || proc_b == 8'h23) begin
                if (proc_last) begin
                    load    = 1'b1;
                    ld_kind = (proc_b == 8'h23) ? K_DIR : K_WORD;
                    ld_len  = 8'd1;
                    ld_hash = HASH_W'(proc_b);
                    state_d = S_EOF;
                end else begin
                    kind_d  = (proc_b == 8'h23) ? K_DIR : K_WORD;
                    len_d   = 8'd1;
                    hash_d  = HASH_W'(proc_b);
                    line0_d = line_q;
                    trunc_d = 1'b0;
                    state_d = S_WORD;
                end
            end else if (is_ws(proc_b)) begin
                state_d = proc_last ? S_EOF : S_IDLE;
            end else begin
                load    = 1'b1;
                ld_kind = K_PUNCT;
                ld_len  = 8'd1;
                ld_hash = HASH_W'(proc_b);
                state_d = proc_last ? S_EOF : S_IDLE;
            end
        end

        if (acc && bus.in_data == 8'h0A) line_d = line_q + LINE_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            kind_q      <= K_WORD;
            len_q       <= 8'd0;
            hash_q      <= '0;
            line0_q     <= '0;
            trunc_q     <= 1'b0;
            pend_q      <= 8'd0;
            pend_last_q <= 1'b0;
            line_q      <= LINE_W'(1);
            tv_q        <= 1'b0;
            tk_q        <= 2'd0;
            tl_q        <= 8'd0;
            th_q        <= '0;
            tln_q       <= '0;
            tt_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            len_q       <= len_d;
            hash_q      <= hash_d;
            line0_q     <= line0_d;
            trunc_q     <= trunc_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            line_q      <= line_d;
            if (load) begin
                tv_q  <= 1'b1;
                tk_q  <= ld_kind;
                tl_q  <= ld_len;
                th_q  <= ld_hash;
                tln_q <= ld_line;
                tt_q  <= ld_trunc;
            end else if (bus.tok_ready) begin
                tv_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.tok_valid = tv_q;
    assign bus.tok_kind  = tk_q;
    assign bus.tok_len   = tl_q;
    assign bus.tok_hash  = th_q;
    assign bus.tok_line  = tln_q;
    assign bus.tok_trunc = tt_q;
endmodule

// File: tb/tb_kw_token_scanner.sv
// Scoreboard bench for kw_token_scanner: directed vectors with hand-derived
// tokens, then a random byte stream checked against a behavioural scanner.
module tb_kw_token_scanner;
    localparam int MAX_LEN = 16;
    localparam int HASH_W  = 12;
    localparam int LINE_W  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kw_token_scanner_if #(.HASH_W(HASH_W), .LINE_W(LINE_W)) bus();

    kw_token_scanner #(.MAX_LEN(MAX_LEN), .HASH_W(HASH_W), .LINE_W(LINE_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0]        kind;
        logic [7:0]        len;
        logic [HASH_W-1:0] hash;
        logic [LINE_W-1:0] line;
        logic              trunc;
    } tok_t;

    tok_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rnd_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [HASH_W-1:0] rot_xor(input logic [HASH_W-1:0] h, input logic [7:0] b);
        logic [HASH_W-1:0] r;
        r = (h << 5) | (h >> (HASH_W - 5));
        return r ^ HASH_W'(b);
    endfunction

    function automatic logic [HASH_W-1:0] hash_str(input string s);
        logic [HASH_W-1:0] h = '0;
        for (int i = 0; i < s.len() && i < MAX_LEN; i++) h = rot_xor(h, s[i]);
        return h;
    endfunction

    task automatic push_exp(input logic [1:0] k, input int len, input logic [HASH_W-1:0] h,
                            input int line, input logic tr);
        tok_t t;
        t.kind = k; t.len = 8'(len); t.hash = h; t.line = LINE_W'(line); t.trunc = tr;
        exp_q.push_back(t);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.tok_valid && bus.tok_ready) begin
            check("tok_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                tok_t e;
                e = exp_q.pop_front();
                check("tok_kind",  32'(bus.tok_kind),  32'(e.kind));
                check("tok_len",   32'(bus.tok_len),   32'(e.len));
                check("tok_hash",  32'(bus.tok_hash),  32'(e.hash));
                check("tok_line",  32'(bus.tok_line),  32'(e.line));
                check("tok_trunc", 32'(bus.tok_trunc), 32'(e.trunc));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        for (int n = 0; n <= 300; n++) begin
            if (rnd_ready) bus.tok_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_ready) break;
            if (n == 300) check("accept_timeout", 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1));
    endtask

    task automatic drain();
        bus.tok_ready = 1'b1;
        for (int n = 0; n <= 500; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.tok_valid) break;
            if (n == 500) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.tok_valid), 32'd0);
        check({tag, "_ready"}, 32'(bus.in_ready),  32'd0);
        check({tag, "_kind"},  32'(bus.tok_kind),  32'd0);
        check({tag, "_len"},   32'(bus.tok_len),   32'd0);
        check({tag, "_hash"},  32'(bus.tok_hash),  32'd0);
        check({tag, "_line"},  32'(bus.tok_line),  32'd0);
        check({tag, "_trunc"}, 32'(bus.tok_trunc), 32'd0);
    endtask

    // Behavioural scanner for the random phase.
    logic              m_inword;
    logic [1:0]        m_kind;
    int                m_len;
    logic [HASH_W-1:0] m_hash;
    logic              m_trunc;
    int                m_line0, m_line;

    function automatic bit is_wc(input logic [7:0] b);
        return b inside {[8'h61:8'h7A], [8'h41:8'h5A], [8'h30:8'h39], 8'h5F, 8'h24};
    endfunction

    task automatic m_start(input logic [7:0] b);
        if (is_wc(b) || b == 8'h23) begin
            m_inword = 1'b1; m_kind = (b == 8'h23) ? 2'd1 : 2'd0;
            m_len = 1; m_hash = HASH_W'(b); m_trunc = 1'b0; m_line0 = m_line;
        end else if (!(b inside {8'h20, 8'h09, 8'h0D, 8'h0A})) begin
            push_exp(2'd2, 1, HASH_W'(b), m_line, 1'b0);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input logic last);
        if (m_inword && is_wc(b)) begin
            if (m_len < MAX_LEN) begin m_len++; m_hash = rot_xor(m_hash, b); end
            else m_trunc = 1'b1;
        end else begin
            if (m_inword) begin
                push_exp(m_kind, m_len, m_hash, m_line0, m_trunc);
                m_inword = 1'b0;
            end
            m_start(b);
        end
        if (b == 8'h0A) m_line++;
        if (last) begin
            if (m_inword) push_exp(m_kind, m_len, m_hash, m_line0, m_trunc);
            m_inword = 1'b0;
            push_exp(2'd3, 0, '0, m_line, 1'b0);
            m_line = 1;
        end
    endtask

    initial begin
        string s;
        string alpha;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0; bus.tok_ready = 1'b1;
        #12;
        check_reset_outputs("rst0");
        #10 rst_n = 1'b1;
        #1 check("ready_after_rst", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        push_exp(2'd0, 2, 12'hD92, 1, 1'b0);
        send_str("or ", 1'b0);
        drain();

        push_exp(2'd0, 1, 12'h061, 1, 1'b0);
        push_exp(2'd2, 1, 12'h03B, 1, 1'b0);
        push_exp(2'd0, 1, 12'h062, 1, 1'b0);
        push_exp(2'd3, 0, 12'h000, 1, 1'b0);
        send_str("a;b", 1'b1);
        drain();

        push_exp(2'd1, 7, hash_str("#define"), 1, 1'b0);
        push_exp(2'd0, 4, hash_str("wire"), 2, 1'b0);
        push_exp(2'd3, 0, 12'h000, 3, 1'b0);
        send_str("#define\nwire\n", 1'b1);
        drain();

        s = "";
        for (int i = 0; i < 20; i++) s = {s, "a"};
        push_exp(2'd0, 16, hash_str(s), 1, 1'b1);
        push_exp(2'd0, 1, 12'h062, 1, 1'b0);
        send_str({s, " b "}, 1'b0);
        drain();

        push_exp(2'd0, 1, 12'h078, 1, 1'b0);
        push_exp(2'd2, 1, 12'h02B, 1, 1'b0);
        push_exp(2'd0, 1, 12'h079, 1, 1'b0);
        bus.tok_ready = 1'b0;
        send_str("x+", 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.tok_valid), 32'd1);
            check("stall_kind",  32'(bus.tok_kind),  32'd0);
            check("stall_len",   32'(bus.tok_len),   32'd1);
            check("stall_hash",  32'(bus.tok_hash),  32'h078);
            check("stall_ready", 32'(bus.in_ready),  32'd0);
        end
        @(posedge clk); #1;
        bus.tok_ready = 1'b1;
        send_str("y ", 1'b0);
        drain();

        send_str("\nmodu", 1'b0);
        rst_n = 1'b0;
        #2 check_reset_outputs("rst_mid");
        @(negedge clk); rst_n = 1'b1;
        #1 check("ready_after_rst2", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        push_exp(2'd0, 3, hash_str("end"), 1, 1'b0);
        send_str("end ", 1'b0);
        drain();

        alpha = "aabbc_Z9$xyzq#;+( \n\t";
        m_inword = 1'b0; m_line = 1; m_line0 = 1; m_len = 0; m_hash = '0;
        m_kind = 2'd0; m_trunc = 1'b0;
        rnd_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            logic       l;
            b = alpha[$urandom_range(0, alpha.len() - 1)];
            if ($urandom_range(0, 9) == 0) for (int k = 0; k < 18; k++) begin
                model_byte(8'h6B, 1'b0);
                send_byte(8'h6B, 1'b0);
            end
            l = (i == 399) || ($urandom_range(0, 59) == 0);
            model_byte(b, l);
            send_byte(b, l);
        end
        rnd_ready = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
